// File: rtl/bb_core_pkg.sv
// Shared definitions for bb_core: default data width, select-width helper and
// the PC-source encoding used by the register bank's PC mux.
package bb_core_pkg;

   localparam int DATA_WIDTH_DEF = 16;

   // A bank of two registers still needs a one-bit select.
   function automatic int sel_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   typedef enum logic [2:0] {
      PC_SRC_HOLD   = 3'd0,
      PC_SRC_STEP   = 3'd1,
      PC_SRC_BRANCH = 3'd2,
      PC_SRC_CALL   = 3'd3,
      PC_SRC_RET    = 3'd4
   } pc_src_e;

endpackage

// File: rtl/bb_register_bank_if.sv
// Port bundle of bb_register_bank: register read/write/increment, IR load and PC control.
// There is no handshake: every i_* command is a single-cycle strobe sampled on the rising clk edge.
interface bb_register_bank_if #(
   parameter int DATA_WIDTH = 16,
   parameter int SEL_W      = 3
);
   logic                  i_wr_en;
   logic [SEL_W-1:0]      i_wr_sel;
   logic [DATA_WIDTH-1:0] i_wr_data;
   logic                  i_inc_en;
   logic [SEL_W-1:0]      i_inc_sel;
   logic [SEL_W-1:0]      i_rd0_sel;
   logic [SEL_W-1:0]      i_rd1_sel;
   logic [DATA_WIDTH-1:0] o_rd0_data;
   logic [DATA_WIDTH-1:0] o_rd1_data;
   logic                  i_ir_load;
   logic [DATA_WIDTH-1:0] i_fetch_data;
   logic                  i_pc_step;
   logic                  i_branch_en;
   logic [DATA_WIDTH-1:0] i_branch_addr;
   logic                  i_call;
   logic                  i_ret;
   logic [DATA_WIDTH-1:0] o_pc;
   logic [DATA_WIDTH-1:0] o_ir;
   logic                  o_stack_full;
   logic                  o_stack_empty;
   logic                  o_stack_err;

   modport master (
      output i_wr_en, i_wr_sel, i_wr_data, i_inc_en, i_inc_sel,
      output i_rd0_sel, i_rd1_sel, i_ir_load, i_fetch_data,
      output i_pc_step, i_branch_en, i_branch_addr, i_call, i_ret,
      input  o_rd0_data, o_rd1_data, o_pc, o_ir,
      input  o_stack_full, o_stack_empty, o_stack_err
   );

   modport slave (
      input  i_wr_en, i_wr_sel, i_wr_data, i_inc_en, i_inc_sel,
      input  i_rd0_sel, i_rd1_sel, i_ir_load, i_fetch_data,
      input  i_pc_step, i_branch_en, i_branch_addr, i_call, i_ret,
      output o_rd0_data, o_rd1_data, o_pc, o_ir,
      output o_stack_full, o_stack_empty, o_stack_err
   );
endinterface

// File: rtl/bb_pc_stack.sv
// Return-address LIFO for the PC. Overflow, underflow and push/pop conflicts
// set a sticky error that only reset clears; a rejected push leaves contents intact.
module bb_pc_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             conflict_i,
   input  logic [WIDTH-1:0] push_data_i,
   output logic [WIDTH-1:0] top_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             err_o
);
   localparam int PTR_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] sp_q, sp_d;
   logic             err_q, err_d;
   logic             push_ok;

   assign full_o  = (sp_q == PTR_W'(DEPTH));
   assign empty_o = (sp_q == '0);
   assign err_o   = err_q;
   assign push_ok = push_i && !conflict_i && !full_o;

   always_comb begin
      top_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (sp_q == PTR_W'(i + 1)) top_o = mem_q[i];
      end
   end

   always_comb begin
      sp_d  = sp_q;
      err_d = err_q;
      if (conflict_i) begin
         err_d = 1'b1;
      end else if (push_i) begin
         if (full_o) err_d = 1'b1;
         else        sp_d  = sp_q + PTR_W'(1);
      end else if (pop_i) begin
         if (empty_o) err_d = 1'b1;
         else         sp_d  = sp_q - PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sp_q  <= '0;
         err_q <= 1'b0;
      end else begin
         sp_q  <= sp_d;
         err_q <= err_d;
      end
   end

   // Entries are only ever read below the stack pointer, so they need no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (push_ok && sp_q == PTR_W'(i)) mem_q[i] <= push_data_i;
      end
   end
endmodule

// File: rtl/bb_register_bank.sv
// Architectural register state of bb_core: general registers, IR and PC.
// Build option BB_PC_STACK_EN adds the hardware call/return stack (bb_pc_stack).
module bb_register_bank
   import bb_core_pkg::*;
#(
   parameter int                    DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int                    NUM_REGS    = 8,
   parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
   parameter int                    STACK_DEPTH = 4
) (
   input logic               clk,
   input logic               rst,
   bb_register_bank_if.slave rb
);
   localparam int SEL_W = sel_width(NUM_REGS);

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
   logic [DATA_WIDTH-1:0] ir_q, ir_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d, pc_inc;
   logic [DATA_WIDTH-1:0] stk_top;
   pc_src_e               pc_src;

   // Selects beyond NUM_REGS match no entry, so they are ignored on write and read 0.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
         if (rb.i_inc_en && rb.i_inc_sel == SEL_W'(i)) regs_d[i] = regs_q[i] + DATA_WIDTH'(1);
         if (rb.i_wr_en && rb.i_wr_sel == SEL_W'(i))   regs_d[i] = rb.i_wr_data;
      end
   end

   always_comb begin
      rb.o_rd0_data = '0;
      rb.o_rd1_data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rb.i_rd0_sel == SEL_W'(i)) rb.o_rd0_data = regs_q[i];
         if (rb.i_rd1_sel == SEL_W'(i)) rb.o_rd1_data = regs_q[i];
      end
   end

   assign ir_d   = rb.i_ir_load ? rb.i_fetch_data : ir_q;
   assign pc_inc = pc_q + DATA_WIDTH'(1);

`ifdef BB_PC_STACK_EN
   logic stk_push, stk_pop, stk_conflict, stk_full, stk_empty, stk_err;

   always_comb begin
      pc_src       = PC_SRC_HOLD;
      stk_push     = 1'b0;
      stk_pop      = 1'b0;
      stk_conflict = 1'b0;
      if (rb.i_call && rb.i_ret) begin
         stk_conflict = 1'b1;
      end else if (rb.i_ret) begin
         stk_pop = 1'b1;
         if (!stk_empty) pc_src = PC_SRC_RET;
      end else if (rb.i_call) begin
         // A call on a full stack loses its return address but still branches.
         stk_push = 1'b1;
         pc_src   = PC_SRC_CALL;
      end else if (rb.i_branch_en) begin
         pc_src = PC_SRC_BRANCH;
      end else if (rb.i_pc_step) begin
         pc_src = PC_SRC_STEP;
      end
   end

   bb_pc_stack #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (STACK_DEPTH)
   ) u_pc_stack (
      .clk         (clk),
      .rst         (rst),
      .push_i      (stk_push),
      .pop_i       (stk_pop),
      .conflict_i  (stk_conflict),
      .push_data_i (pc_inc),
      .top_o       (stk_top),
      .full_o      (stk_full),
      .empty_o     (stk_empty),
      .err_o       (stk_err)
   );

   assign rb.o_stack_full  = stk_full;
   assign rb.o_stack_empty = stk_empty;
   assign rb.o_stack_err   = stk_err;
`else
   logic unused_ret;

   // Without a stack a call is a plain branch and a return does nothing.
   always_comb begin
      pc_src = PC_SRC_HOLD;
      if (rb.i_call || rb.i_branch_en) pc_src = PC_SRC_BRANCH;
      else if (rb.i_pc_step)           pc_src = PC_SRC_STEP;
   end

   assign unused_ret       = rb.i_ret;
   assign stk_top          = '0;
   assign rb.o_stack_full  = 1'b0;
   assign rb.o_stack_empty = 1'b1;
   assign rb.o_stack_err   = 1'b0;
`endif

   always_comb begin
      pc_d = pc_q;
      case (pc_src)
         PC_SRC_STEP:                pc_d = pc_inc;
         PC_SRC_BRANCH, PC_SRC_CALL: pc_d = rb.i_branch_addr;
         PC_SRC_RET:                 pc_d = stk_top;
         default:                    pc_d = pc_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         ir_q <= '0;
         pc_q <= RESET_PC;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
         ir_q <= ir_d;
         pc_q <= pc_d;
      end
   end

   assign rb.o_pc = pc_q;
   assign rb.o_ir = ir_q;
endmodule

// File: tb/tb_bb_register_bank.sv
// Self-checking bench for bb_register_bank (NUM_REGS=6); stack checks follow BB_PC_STACK_EN.
module tb_bb_register_bank;
   localparam int          W     = 16;
   localparam int          NR    = 6;
   localparam int          SW    = 3;
   localparam int          DEPTH = 4;
   localparam logic [15:0] RPC   = 16'h0000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bb_register_bank_if #(.DATA_WIDTH(W), .SEL_W(SW)) rb ();

   bb_register_bank #(
      .DATA_WIDTH  (W),
      .NUM_REGS    (NR),
      .RESET_PC    (RPC),
      .STACK_DEPTH (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .rb  (rb.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: plain arrays, a queue for the return stack.
   logic [15:0] m_regs [NR];
   logic [15:0] m_pc, m_ir;
   logic [15:0] m_stk [$];
   bit          m_err;

   typedef struct {
      bit          wr_en;
      logic [2:0]  wr_sel;
      logic [15:0] wr_data;
      bit          inc_en;
      logic [2:0]  inc_sel;
      logic [2:0]  rd_sel;
      logic [15:0] exp;
   } vec_t;
   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] m_read(input logic [2:0] sel);
      return (int'(sel) < NR) ? m_regs[sel] : 16'h0000;
   endfunction

   task automatic idle_cmds();
      rb.i_wr_en = 0; rb.i_wr_sel = '0; rb.i_wr_data = '0;
      rb.i_inc_en = 0; rb.i_inc_sel = '0;
      rb.i_ir_load = 0; rb.i_fetch_data = '0;
      rb.i_pc_step = 0; rb.i_branch_en = 0; rb.i_branch_addr = '0;
      rb.i_call = 0; rb.i_ret = 0;
   endtask

   task automatic model_update();
      if (rst) begin
         for (int i = 0; i < NR; i++) m_regs[i] = 16'h0000;
         m_ir = 16'h0000; m_pc = RPC; m_stk.delete(); m_err = 0;
         return;
      end
      if (rb.i_inc_en && int'(rb.i_inc_sel) < NR) m_regs[rb.i_inc_sel] = m_regs[rb.i_inc_sel] + 16'h1;
      if (rb.i_wr_en && int'(rb.i_wr_sel) < NR)   m_regs[rb.i_wr_sel] = rb.i_wr_data;
      if (rb.i_ir_load) m_ir = rb.i_fetch_data;
`ifdef BB_PC_STACK_EN
      if (rb.i_call && rb.i_ret) m_err = 1;
      else if (rb.i_ret) begin
         if (m_stk.size() == 0) m_err = 1;
         else m_pc = m_stk.pop_back();
      end else if (rb.i_call) begin
         if (m_stk.size() == DEPTH) m_err = 1;
         else m_stk.push_back(m_pc + 16'h1);
         m_pc = rb.i_branch_addr;
      end else if (rb.i_branch_en) m_pc = rb.i_branch_addr;
      else if (rb.i_pc_step) m_pc = m_pc + 16'h1;
`else
      if (rb.i_call || rb.i_branch_en) m_pc = rb.i_branch_addr;
      else if (rb.i_pc_step) m_pc = m_pc + 16'h1;
`endif
   endtask

   task automatic tick();
      model_update();
      @(posedge clk);
      #1;
      idle_cmds();
   endtask

   task automatic check_model(input string tag);
      check({tag, ".rd0"}, rb.o_rd0_data, m_read(rb.i_rd0_sel));
      check({tag, ".rd1"}, rb.o_rd1_data, m_read(rb.i_rd1_sel));
      check({tag, ".pc"}, rb.o_pc, m_pc);
      check({tag, ".ir"}, rb.o_ir, m_ir);
      check({tag, ".full"}, rb.o_stack_full, m_stk.size() == DEPTH);
      check({tag, ".empty"}, rb.o_stack_empty, m_stk.size() == 0);
      check({tag, ".err"}, rb.o_stack_err, m_err);
   endtask

   task automatic do_branch(input logic [15:0] a);
      rb.i_branch_en = 1; rb.i_branch_addr = a; tick();
   endtask

   task automatic do_call(input logic [15:0] a);
      rb.i_call = 1; rb.i_branch_addr = a; tick();
   endtask

   initial begin
      rst = 1;
      idle_cmds();
      rb.i_rd0_sel = '0; rb.i_rd1_sel = 3'd1;
      tick(); tick();
      check("reset.pc", rb.o_pc, RPC);
      check("reset.ir", rb.o_ir, 16'h0000);
      check("reset.rd0", rb.o_rd0_data, 16'h0000);
      check("reset.empty", rb.o_stack_empty, 1'b1);
      check("reset.full", rb.o_stack_full, 1'b0);
      check("reset.err", rb.o_stack_err, 1'b0);
      rst = 0;

      //          wr  sel   data       inc sel   rd    exp
      vecs[0] = '{1, 3'd3, 16'h1234, 0, 3'd0, 3'd3, 16'h1234};
      vecs[1] = '{0, 3'd0, 16'h0000, 1, 3'd3, 3'd3, 16'h1235};
      vecs[2] = '{0, 3'd0, 16'h0000, 1, 3'd3, 3'd3, 16'h1236};
      vecs[3] = '{1, 3'd3, 16'h0010, 1, 3'd3, 3'd3, 16'h0010};
      vecs[4] = '{1, 3'd1, 16'hFFFF, 0, 3'd0, 3'd1, 16'hFFFF};
      vecs[5] = '{0, 3'd0, 16'h0000, 1, 3'd1, 3'd1, 16'h0000};
      vecs[6] = '{1, 3'd7, 16'hAAAA, 0, 3'd0, 3'd7, 16'h0000};
      vecs[7] = '{1, 3'd5, 16'hBEEF, 1, 3'd2, 3'd5, 16'hBEEF};
      vecs[8] = '{0, 3'd0, 16'h0000, 0, 3'd0, 3'd2, 16'h0001};
      vecs[9] = '{1, 3'd6, 16'h5555, 1, 3'd7, 3'd6, 16'h0000};
      for (int i = 0; i < 10; i++) begin
         rb.i_wr_en = vecs[i].wr_en; rb.i_wr_sel = vecs[i].wr_sel; rb.i_wr_data = vecs[i].wr_data;
         rb.i_inc_en = vecs[i].inc_en; rb.i_inc_sel = vecs[i].inc_sel;
         rb.i_rd0_sel = vecs[i].rd_sel; rb.i_rd1_sel = 3'($urandom_range(0, 7));
         tick();
         check($sformatf("vec%0d", i), rb.o_rd0_data, vecs[i].exp);
         check_model($sformatf("vec%0d", i));
      end

      // Sweep every select, including out-of-range ones, on both ports.
      for (int s = 0; s < 8; s++) begin
         rb.i_rd0_sel = 3'(s); rb.i_rd1_sel = 3'(7 - s); #1;
         check($sformatf("sweep%0d.rd0", s), rb.o_rd0_data, m_read(3'(s)));
         check($sformatf("sweep%0d.rd1", s), rb.o_rd1_data, m_read(3'(7 - s)));
      end

      // No write bypass: a write is invisible until the following cycle.
      rb.i_wr_en = 1; rb.i_wr_sel = 3'd4; rb.i_wr_data = 16'h7777; rb.i_rd0_sel = 3'd4; #1;
      check("nobypass.before", rb.o_rd0_data, 16'h0000);
      tick();
      check("nobypass.after", rb.o_rd0_data, 16'h7777);

      rb.i_ir_load = 1; rb.i_fetch_data = 16'hABCD; tick();
      check("ir.load", rb.o_ir, 16'hABCD);
      rb.i_fetch_data = 16'h1111; tick();
      check("ir.hold", rb.o_ir, 16'hABCD);

      do_branch(16'h0010);
      check("pc.branch", rb.o_pc, 16'h0010);
      rb.i_pc_step = 1; rb.i_branch_en = 1; rb.i_branch_addr = 16'h0200; tick();
      check("pc.branch_over_step", rb.o_pc, 16'h0200);
      rb.i_pc_step = 1; tick();
      check("pc.step", rb.o_pc, 16'h0201);
      tick();
      check("pc.hold", rb.o_pc, 16'h0201);
      do_branch(16'hFFFF);
      rb.i_pc_step = 1; tick();
      check("pc.step_wrap", rb.o_pc, 16'h0000);
      check_model("pc");

`ifdef BB_PC_STACK_EN
      do_branch(16'h0100);
      do_call(16'h0300);
      check("call1.pc", rb.o_pc, 16'h0300);
      check("call1.empty", rb.o_stack_empty, 1'b0);
      rb.i_pc_step = 1; tick();
      rb.i_pc_step = 1; tick();
      do_call(16'h0400);
      check("call2.pc", rb.o_pc, 16'h0400);
      rb.i_ret = 1; tick();
      check("ret1.pc", rb.o_pc, 16'h0303);
      rb.i_ret = 1; tick();
      check("ret2.pc", rb.o_pc, 16'h0101);
      check("ret2.empty", rb.o_stack_empty, 1'b1);
      do_call(16'h0700);
      rb.i_ret = 1; tick();
      check("roundtrip.pc", rb.o_pc, 16'h0102);
      check_model("nest");
      for (int k = 0; k < 5; k++) begin
         do_call(16'h1000 + 16'(k));
         if (k == 3) begin
            check("call4.full", rb.o_stack_full, 1'b1);
            check("call4.err", rb.o_stack_err, 1'b0);
         end
      end
      check("call5.pc", rb.o_pc, 16'h1004);
      check("call5.full", rb.o_stack_full, 1'b1);
      check("call5.err", rb.o_stack_err, 1'b1);
      for (int k = 0; k < 4; k++) begin
         rb.i_ret = 1; tick();
         check_model($sformatf("unwind%0d", k));
      end
      check("unwind.pc", rb.o_pc, 16'h0103);
      check("unwind.empty", rb.o_stack_empty, 1'b1);
      rb.i_ret = 1; tick();
      check("ret_empty.pc", rb.o_pc, 16'h0103);
      check("ret_empty.err", rb.o_stack_err, 1'b1);
      rb.i_call = 1; rb.i_ret = 1; rb.i_branch_addr = 16'h0900; tick();
      check("callret.pc", rb.o_pc, 16'h0103);
      do_call(16'h0A00);
      rst = 1; rb.i_call = 1; rb.i_branch_addr = 16'h0B00; tick();
      rst = 0;
      check("rst.pc", rb.o_pc, RPC);
      check("rst.err", rb.o_stack_err, 1'b0);
      check("rst.empty", rb.o_stack_empty, 1'b1);
      check_model("rst");
`else
      do_call(16'h0500);
      check("nostk.call.pc", rb.o_pc, 16'h0500);
      check("nostk.call.empty", rb.o_stack_empty, 1'b1);
      rb.i_ret = 1; tick();
      check("nostk.ret.pc", rb.o_pc, 16'h0500);
      check("nostk.ret.empty", rb.o_stack_empty, 1'b1);
      check("nostk.ret.err", rb.o_stack_err, 1'b0);
      check("nostk.full", rb.o_stack_full, 1'b0);
      check_model("nostk");
`endif

      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 63) == 0);
         rb.i_wr_en = $urandom_range(0, 1); rb.i_wr_sel = 3'($urandom_range(0, 7));
         rb.i_wr_data = 16'($urandom);
         if ($urandom_range(0, 7) == 0) rb.i_wr_data = 16'hFFFF;
         rb.i_inc_en = $urandom_range(0, 1); rb.i_inc_sel = 3'($urandom_range(0, 7));
         rb.i_rd0_sel = 3'($urandom_range(0, 7)); rb.i_rd1_sel = 3'($urandom_range(0, 7));
         rb.i_ir_load = $urandom_range(0, 1); rb.i_fetch_data = 16'($urandom);
         rb.i_pc_step = $urandom_range(0, 1); rb.i_branch_en = ($urandom_range(0, 3) == 0);
         rb.i_branch_addr = 16'($urandom);
         rb.i_call = ($urandom_range(0, 4) == 0); rb.i_ret = ($urandom_range(0, 4) == 0);
         tick();
         rst = 0;
         check_model($sformatf("rand%0d", c));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
